uz_foc_mul_pipe: RTL and testbench

Parametrised, pipelined unsigned × signed fixed-point multiplier for the FOC datapath, succeeding the fixed 6×25-bit, 4-stage DSP48 multiplier. Adds configurable operand/result widths, configurable latency, a valid pipeline, a binary-point shift with round-half-up, and overflow detection. Sits between the PI/transform stages wherever a gain (unsigned) scales a signed current/voltage quantity.

---
 rtl/uz_foc_mul_pipe_pkg.sv | 13 +
 rtl/uz_foc_mul_pipe_if.sv | 16 +
 rtl/uz_foc_mul_pipe_round_sat.sv | 28 ++
 rtl/uz_foc_mul_pipe.sv | 51 +++++
 tb/tb_uz_foc_mul_pipe.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/uz_foc_mul_pipe_pkg.sv
// uz_foc_mul_pkg: shared constants and width/range helpers for the FOC multiplier
package uz_foc_mul_pkg;
  localparam int UZ_FOC_MUL_MIN_STAGE = 3;
  function automatic int full_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction
  function automatic longint p_max(input int p_w);
    return (64'sd1 <<< (p_w - 1)) - 64'sd1;
  endfunction
  function automatic longint p_min(input int p_w);
    return -(64'sd1 <<< (p_w - 1));
  endfunction
endpackage

// File: rtl/uz_foc_mul_pipe_if.sv
// uz_foc_mul_pipe_if: clock-enable, operand and result bundle of the FOC multiplier
interface uz_foc_mul_pipe_if #(
  parameter int A_WIDTH = 6,
  parameter int B_WIDTH = 25,
  parameter int P_WIDTH = 25
);
  logic ce;
  logic din_valid;
  logic [A_WIDTH-1:0] din0;
  logic signed [B_WIDTH-1:0] din1;
  logic dout_valid;
  logic signed [P_WIDTH-1:0] dout;
  logic ovf;
  modport master (output ce, din_valid, din0, din1, input dout_valid, dout, ovf);
  modport slave (input ce, din_valid, din0, din1, output dout_valid, dout, ovf);
endinterface

// File: rtl/uz_foc_mul_pipe_round_sat.sv
// uz_foc_round_sat: round-half-up binary-point shift and range reduction of the full product
// UZ_FOC_MUL_SAT_EN selects clipping to the P_WIDTH limits instead of two's-complement wrap
module uz_foc_round_sat import uz_foc_mul_pkg::*; #(
  parameter int A_WIDTH = 6,
  parameter int B_WIDTH = 25,
  parameter int P_WIDTH = 25,
  parameter int FRAC_SHIFT = 0
) (
  input  logic signed [full_width(A_WIDTH, B_WIDTH)-1:0] prod_i,
  output logic signed [P_WIDTH-1:0] res_o,
  output logic ovf_o
);
  localparam int SW = full_width(A_WIDTH, B_WIDTH) + 1;
  localparam int RS = FRAC_SHIFT > 0 ? FRAC_SHIFT - 1 : 0;
  localparam logic [SW-1:0] RND = SW'(FRAC_SHIFT > 0) << RS;
  logic signed [SW-1:0] sum, shf;
  logic fit;
  // one guard bit keeps the rounding add from overflowing at the most positive product
  assign sum = {prod_i[SW-2], prod_i} + RND;
  assign shf = sum >>> FRAC_SHIFT;
  assign fit = &shf[SW-1:P_WIDTH-1] | ~|shf[SW-1:P_WIDTH-1];
  assign ovf_o = !fit;
`ifdef UZ_FOC_MUL_SAT_EN
  assign res_o = fit ? shf[P_WIDTH-1:0] : {shf[SW-1], {(P_WIDTH-1){!shf[SW-1]}}};
`else
  assign res_o = shf[P_WIDTH-1:0];
`endif
endmodule

// File: rtl/uz_foc_mul_pipe.sv
// uz_foc_mul_pipe: pipelined unsigned x signed fixed-point multiplier with valid pipe and ovf
// UZ_FOC_MUL_SAT_EN (in uz_foc_round_sat) clips out-of-range results instead of wrapping
module uz_foc_mul_pipe import uz_foc_mul_pkg::*; #(
  parameter int A_WIDTH = 6,
  parameter int B_WIDTH = 25,
  parameter int P_WIDTH = 25,
  parameter int FRAC_SHIFT = 0,
  parameter int NUM_STAGE = 4
) (
  input logic clk,
  input logic reset,
  uz_foc_mul_pipe_if.slave bus
);
  localparam int FW = full_width(A_WIDTH, B_WIDTH);
  localparam int D = NUM_STAGE - UZ_FOC_MUL_MIN_STAGE + 1;
  localparam int W = P_WIDTH + 2;
  logic [A_WIDTH-1:0] a_q;
  logic signed [B_WIDTH-1:0] b_q;
  logic signed [FW-1:0] p_q;
  logic v1_q, v2_q;
  logic signed [P_WIDTH-1:0] res_d;
  logic ovf_d;
  logic [W-1:0] dly_q [D];
  uz_foc_round_sat #(
    .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .P_WIDTH(P_WIDTH), .FRAC_SHIFT(FRAC_SHIFT)
  ) u_round_sat (
    .prod_i(p_q),
    .res_o(res_d),
    .ovf_o(ovf_d)
  );
  // input, M and P registers share the sync reset and ce so they fold into one DSP slice
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      for (int i = 0; i < D; i++) dly_q[i] <= '0;
    end else if (bus.ce) begin
      a_q <= bus.din0;
      b_q <= bus.din1;
      v1_q <= bus.din_valid;
      p_q <= FW'($signed({1'b0, a_q})) * FW'(b_q);
      v2_q <= v1_q;
      dly_q[0] <= {v2_q, ovf_d, res_d};
      for (int i = 1; i < D; i++) dly_q[i] <= dly_q[i-1];
    end
  end
  assign {bus.dout_valid, bus.ovf, bus.dout} = dly_q[D-1];
endmodule

// File: tb/tb_uz_foc_mul_pipe.sv
// tb_uz_foc_mul_pipe: directed checks of latency, stall, range reduction, rounding and reset
module tb_uz_foc_mul_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errs = 0;
  int checks = 0;
  int lat, seen;
  logic signed [24:0] d, rd;
  logic o, ro;
`ifdef UZ_FOC_MUL_SAT_EN
  localparam int BIG_POS = 16777215;
`else
  localparam int BIG_POS = 16777153;
`endif
  uz_foc_mul_pipe_if #(.A_WIDTH(6), .B_WIDTH(25), .P_WIDTH(25)) m ();
  uz_foc_mul_pipe_if #(.A_WIDTH(6), .B_WIDTH(25), .P_WIDTH(25)) r ();
  uz_foc_mul_pipe dut (.clk(clk), .reset(reset), .bus(m));
  uz_foc_mul_pipe #(.FRAC_SHIFT(4)) dut_r (.clk(clk), .reset(reset), .bus(r));
  assign r.ce = m.ce;
  assign r.din_valid = m.din_valid;
  assign r.din0 = m.din0;
  assign r.din1 = m.din1;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int a, input int b, input int sf, input int sn, output int l,
                     output logic signed [24:0] od, output logic oo,
                     output logic signed [24:0] ord, output logic oro);
    m.din0 = 6'(a);
    m.din1 = 25'(b);
    m.din_valid = 1'b1;
    l = -1;
    od = '0;
    oo = 1'b0;
    ord = '0;
    oro = 1'b0;
    for (int i = 1; i <= 20 && l < 0; i++) begin
      step();
      m.din_valid = 1'b0;
      m.din0 = '0;
      m.din1 = '0;
      m.ce = !(i >= sf && i < sf + sn);
      if (m.dout_valid) begin
        l = i;
        od = m.dout;
        oo = m.ovf;
        ord = r.dout;
        oro = r.ovf;
      end
    end
    m.ce = 1'b1;
  endtask

  initial begin
    m.ce = 1'b1;
    m.din_valid = 1'b0;
    m.din0 = '0;
    m.din1 = '0;
    repeat (2) step();
    chk("rst_valid", m.dout_valid, 0);
    chk("rst_dout", m.dout, 0);
    chk("rst_ovf", m.ovf, 0);
    reset = 1'b0;
    step();
    run(5, -7, 0, 0, lat, d, o, rd, ro);
    chk("lat", lat, 4);
    chk("lat_dout", d, -35);
    chk("lat_ovf", o, 0);
    chk("lat_rnd_dout", rd, -2);
    step();
    chk("lat_one_cycle", m.dout_valid, 0);
    run(5, -7, 1, 3, lat, d, o, rd, ro);
    chk("stall_lat", lat, 7);
    chk("stall_dout", d, -35);
    run(63, 16777215, 0, 0, lat, d, o, rd, ro);
    chk("big_pos_dout", d, BIG_POS);
    chk("big_pos_ovf", o, 1);
    run(63, -16777216, 0, 0, lat, d, o, rd, ro);
    chk("big_neg_dout", d, -16777216);
    chk("big_neg_ovf", o, 1);
    run(2, 100, 0, 0, lat, d, o, rd, ro);
    chk("small_dout", d, 200);
    chk("small_ovf", o, 0);
    run(3, -11, 0, 0, lat, d, o, rd, ro);
    chk("rnd_3x-11", rd, -2);
    chk("rnd_3x-11_ovf", ro, 0);
    run(1, 8, 0, 0, lat, d, o, rd, ro);
    chk("rnd_1x8", rd, 1);
    chk("rnd_1x8_ovf", ro, 0);
    run(1, -8, 0, 0, lat, d, o, rd, ro);
    chk("rnd_1x-8", rd, 0);
    chk("rnd_1x-8_ovf", ro, 0);
    for (int j = 0; j < 12; j++) begin
      m.din_valid = j < 8;
      m.din0 = j < 8 ? 6'(j + 1) : '0;
      m.din1 = j < 8 ? 25'(j * 1000 - 3000) : '0;
      step();
      if (j >= 3 && j <= 10) begin
        chk("b2b_valid", m.dout_valid, 1);
        chk("b2b_dout", m.dout, (j - 2) * ((j - 3) * 1000 - 3000));
      end
    end
    chk("b2b_end", m.dout_valid, 0);
    m.din0 = 6'd5;
    m.din1 = -25'sd7;
    m.din_valid = 1'b1;
    step();
    m.din_valid = 1'b0;
    m.din0 = '0;
    m.din1 = '0;
    step();
    reset = 1'b1;
    m.ce = 1'b0;
    m.din_valid = 1'b1;
    m.din0 = 6'd2;
    m.din1 = 25'sd100;
    step();
    reset = 1'b0;
    m.ce = 1'b1;
    m.din_valid = 1'b0;
    m.din0 = '0;
    m.din1 = '0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m.dout_valid) seen++;
    end
    chk("rst_mid_novalid", seen, 0);
    chk("rst_mid_dout", m.dout, 0);
    chk("rst_mid_ovf", m.ovf, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
